// File: rtl/regfile_host_port_pkg.sv
// Shared definitions for the register-file host port: default geometry,
// command opcodes and FSM state encodings.
package regfile_host_port_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NREGS  = 16;

    // cmd_op encoding seen on the command interface
    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_DUMP = 1'b1
    } op_e;

    // state    | meaning
    // ST_IDLE  | waiting for a command, cmd_ready high
    // ST_LOAD  | accepting stream bytes and writing consecutive registers
    // ST_DUMP  | reading consecutive registers out onto the stream
    // ST_DONE  | one-cycle end-of-command marker, done high
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_host_port.sv
// Host-side initiator for the register file. LOAD moves bytes from a
// valid/ready input stream into consecutive registers; DUMP reads consecutive
// registers out onto a valid/ready output stream. Register indices wrap
// modulo NREGS. busy holds off the core while a transfer is in flight.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_LOAD  | accepting stream bytes and writing consecutive registers
// ST_DUMP  | reading consecutive registers out onto the stream
// ST_DONE  | one-cycle end-of-command marker, done high
module regfile_host_port
    import regfile_host_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,

    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(NREGS);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   REM_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(NREGS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [ADDR_W:0]     rem_q,   rem_d;

    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                ovalid_q, ovalid_d;
    logic [DATA_W-1:0]   odata_q,  odata_d;
    logic                olast_q,  olast_d;

    logic [ADDR_W:0]     len_clamped;
    logic [ADDR_W-1:0]   addr_inc;
    logic                in_ready_w;
    logic                out_hs;
    logic                out_can_load;

    // Lengths above the register count would only revisit registers, so cap them.
    assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

    // Index advance wraps explicitly so NREGS need not be a power of two.
    assign addr_inc = (addr_q == ADDR_TOP) ? '0 : (addr_q + ADDR_ONE);

    assign in_ready_w   = (state_q == ST_LOAD) && (rem_q != REM_ZERO);
    assign out_hs       = ovalid_q && out_ready;
    assign out_can_load = !ovalid_q || out_ready;

    // Next-state and datapath updates; every target gets its hold value first.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        olast_d  = olast_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_base;
                    rem_d  = len_clamped;
                    if (len_clamped == REM_ZERO) begin
                        state_d = ST_DONE;
                    end else if (cmd_op == OP_DUMP) begin
                        state_d = ST_DUMP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                // Write is registered: the byte lands on the regfile port next cycle,
                // so the final write coincides with the DONE cycle.
                if (in_valid && in_ready_w) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    addr_d  = addr_inc;
                    rem_d   = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DUMP: begin
                if (out_hs && olast_q) begin
                    ovalid_d = 1'b0;
                    olast_d  = 1'b0;
                    state_d  = ST_DONE;
                end else if (out_can_load && (rem_q != REM_ZERO)) begin
                    // Output slot is free or being emptied this cycle: refill from
                    // the register currently addressed on the read port.
                    ovalid_d = 1'b1;
                    odata_d  = rf_rdata;
                    olast_d  = (rem_q == REM_ONE);
                    addr_d   = addr_inc;
                    rem_d    = rem_q - REM_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign in_ready  = in_ready_w;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    assign rf_we     = we_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    // The address counter is a register and holds while idle, so the read
    // port keeps its last index between commands.
    assign rf_raddr  = addr_q;

    assign out_valid = ovalid_q;
    assign out_data  = odata_q;
    assign out_last  = olast_q;

endmodule

// File: tb/tb_regfile_host_port.sv
// Bench for regfile_host_port: a behavioural 16x8 register file hangs off the
// DUT's write port and read port; a separate expected-memory array tracks what
// the registers should hold from the command semantics alone.
module tb_regfile_host_port;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_op;
    logic [3:0] cmd_base;
    logic [4:0] cmd_len;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic       rf_we;
    logic [3:0] rf_waddr, rf_raddr;
    logic [7:0] rf_wdata, rf_rdata;
    logic       busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rf_mem  [16];
    logic [7:0] exp_mem [16];
    logic [7:0] load_bytes [$];

    always #5 clk = ~clk;

    regfile_host_port dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .busy      (busy),
        .done      (done)
    );

    // Register file with its own reset, combinational read on rs1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf_mem[rf_raddr];

    function automatic int clamp_len(input int len);
        return (len > 16) ? 16 : len;
    endfunction

    task automatic clear_expected();
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    endtask

    task automatic fill_random_bytes();
        load_bytes.delete();
        for (int i = 0; i < 16; i++) load_bytes.push_back(8'($urandom));
    endtask

    // Presents a command at posedge+1 and returns at posedge+1 of the cycle after acceptance.
    task automatic start_cmd(input logic op, input logic [3:0] base, input logic [4:0] len,
                             output bit ok);
        bit seen;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
        for (int i = 0; i < 8; i++) begin
            seen = (cmd_ready === 1'b1);
            @(posedge clk); #1;
            if (seen) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        cmd_op = 1'($urandom); cmd_base = 4'($urandom); cmd_len = 5'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        clear_expected();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({cmd_ready, busy, done, rf_we, in_ready, out_valid, out_last} !== 7'b1000000)
            $display("FAIL reset_ctrl: got %b expected 1000000",
                     {cmd_ready, busy, done, rf_we, in_ready, out_valid, out_last});
        n_tests++;
        if ({rf_waddr, rf_wdata, rf_raddr, out_data} !== 24'h0)
            $display("FAIL reset_data: got %h expected 000000",
                     {rf_waddr, rf_wdata, rf_raddr, out_data});
        if ({cmd_ready, busy, done, rf_we, in_ready, out_valid, out_last} !== 7'b1000000) n_fail++;
        if ({rf_waddr, rf_wdata, rf_raddr, out_data} !== 24'h0) n_fail++;
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_load(input logic [3:0] base, input int len, input bit bubbles);
        int  n, cyc, hs, wcnt, wfirst, wlast, done_cyc;
        bit  ok, done_seen;
        n = clamp_len(len);
        start_cmd(1'b0, base, 5'(len), ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL load_accept: cmd not accepted base=%0d len=%0d", base, len); end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b expected 1", busy); end
        cyc = 0; hs = 0; wcnt = 0; wfirst = -1; wlast = -1; done_cyc = -1; done_seen = 1'b0;
        while (cyc < 300) begin
            if (rf_we === 1'b1) begin
                wcnt++;
                if (wfirst < 0) wfirst = cyc;
                wlast = cyc;
            end
            if (done === 1'b1) begin
                done_seen = 1'b1; done_cyc = cyc;
                break;
            end
            in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = (hs < n) ? load_bytes[hs] : 8'($urandom);
            if (in_valid && in_ready === 1'b1) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (!done_seen) begin n_fail++; $display("FAIL load_done_timeout: no done within %0d cycles", cyc); end
        n_tests++;
        if (hs != n) begin n_fail++; $display("FAIL load_bytes_taken: got %0d expected %0d", hs, n); end
        n_tests++;
        if (wcnt != n) begin n_fail++; $display("FAIL load_writes: got %0d expected %0d", wcnt, n); end
        if (n > 0) begin
            n_tests++;
            if (wlast != done_cyc) begin
                n_fail++; $display("FAIL load_last_write: got cycle %0d expected done cycle %0d", wlast, done_cyc);
            end
            if (!bubbles) begin
                n_tests++;
                if (wlast - wfirst + 1 != n || done_cyc != n) begin
                    n_fail++;
                    $display("FAIL load_throughput: got span %0d done at %0d expected %0d and %0d",
                             wlast - wfirst + 1, done_cyc, n, n);
                end
            end
        end else begin
            n_tests++;
            if (done_cyc > 1) begin n_fail++; $display("FAIL load_len0_done: got cycle %0d expected <=1", done_cyc); end
        end
        for (int i = 0; i < n; i++) exp_mem[(int'(base) + i) % 16] = load_bytes[i];
        @(posedge clk); #1;
        n_tests++;
        if ({cmd_ready, done, busy, rf_we} !== 4'b1000) begin
            n_fail++; $display("FAIL load_return_idle: got %b expected 1000", {cmd_ready, done, busy, rf_we});
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (rf_mem[i] !== exp_mem[i]) begin
                n_fail++; $display("FAIL load_reg%0d: got %h expected %h", i, rf_mem[i], exp_mem[i]);
            end
        end
    endtask

    // mode 0: out_ready always high; 1: pattern 1,0,0,1,1 over valid cycles; 2: random
    task automatic test_dump(input logic [3:0] base, input int len, input int mode);
        logic [7:0] exp_q [$];
        logic [4:0] pat = 5'b10011;
        logic [7:0] held_d;
        logic       held_l, rdy;
        int  n, cyc, k, pidx, wcnt, last_hs, done_cyc;
        bit  ok, done_seen, stalled, any_valid;
        n = clamp_len(len);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_mem[(int'(base) + i) % 16]);
        start_cmd(1'b1, base, 5'(len), ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL dump_accept: cmd not accepted base=%0d len=%0d", base, len); end
        cyc = 0; k = 0; pidx = 0; wcnt = 0; last_hs = -1; done_cyc = -1;
        done_seen = 1'b0; stalled = 1'b0; any_valid = 1'b0; held_d = '0; held_l = 1'b0;
        while (cyc < 300) begin
            if (rf_we === 1'b1) wcnt++;
            if (done === 1'b1) begin
                done_seen = 1'b1; done_cyc = cyc;
                break;
            end
            if (out_valid === 1'b1) any_valid = 1'b1;
            if (stalled) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    n_fail++;
                    $display("FAIL dump_stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             out_valid, out_data, out_last, held_d, held_l);
                end
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (out_valid === 1'b1) ? pat[4 - (pidx % 5)] : 1'b1;
                default: rdy = 1'($urandom);
            endcase
            if (out_valid === 1'b1) pidx++;
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin
                n_tests++;
                if (k >= n) begin
                    n_fail++; $display("FAIL dump_extra_beat: got beat %0d expected only %0d", k, n);
                end else if (out_data !== exp_q[k] || out_last !== ((k == n - 1) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL dump_beat%0d: got d=%h l=%b expected d=%h l=%b",
                             k, out_data, out_last, exp_q[k], (k == n - 1));
                end
                k++;
                last_hs = cyc;
            end
            stalled = (out_valid === 1'b1) && !rdy;
            held_d  = out_data;
            held_l  = out_last;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        n_tests++;
        if (!done_seen) begin n_fail++; $display("FAIL dump_done_timeout: no done within %0d cycles", cyc); end
        n_tests++;
        if (k != n) begin n_fail++; $display("FAIL dump_beats: got %0d expected %0d", k, n); end
        n_tests++;
        if (wcnt != 0) begin n_fail++; $display("FAIL dump_rf_we: got %0d writes expected 0", wcnt); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dump_valid_in_done: got %b expected 0", out_valid); end
        if (n > 0) begin
            n_tests++;
            if (done_cyc != last_hs + 1) begin
                n_fail++; $display("FAIL dump_done_timing: got %0d expected %0d", done_cyc, last_hs + 1);
            end
            if (mode == 0) begin
                n_tests++;
                if (done_cyc != n + 1) begin
                    n_fail++; $display("FAIL dump_throughput: got done at %0d expected %0d", done_cyc, n + 1);
                end
            end
        end else begin
            n_tests++;
            if (any_valid || done_cyc > 1) begin
                n_fail++; $display("FAIL dump_len0: got valid=%b done at %0d expected 0 and <=1", any_valid, done_cyc);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if ({cmd_ready, done, busy} !== 3'b100) begin
            n_fail++; $display("FAIL dump_return_idle: got %b expected 100", {cmd_ready, done, busy});
        end
    endtask

    task automatic test_reset_mid_load();
        int  hs, wcnt, late;
        bit  ok;
        fill_random_bytes();
        start_cmd(1'b0, 4'd5, 5'd5, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rst_load_accept: cmd not accepted"); end
        hs = 0; wcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (rf_we === 1'b1) wcnt++;
            in_valid = (hs < 2);
            in_data  = load_bytes[hs];
            if (in_valid && in_ready === 1'b1) hs++;
            @(posedge clk); #1;
            if (hs >= 2 && c >= 4) break;
        end
        in_valid = 1'b0;
        if (rf_we === 1'b1) wcnt++;
        n_tests++;
        if (wcnt != 2 || rf_mem[5] !== load_bytes[0] || rf_mem[6] !== load_bytes[1]) begin
            n_fail++;
            $display("FAIL rst_load_partial: got %0d writes r5=%h r6=%h expected 2 %h %h",
                     wcnt, rf_mem[5], rf_mem[6], load_bytes[0], load_bytes[1]);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready, busy, done, rf_we, in_ready, out_valid} !== 6'b100000) begin
            n_fail++;
            $display("FAIL rst_load_outputs: got %b expected 100000",
                     {cmd_ready, busy, done, rf_we, in_ready, out_valid});
        end
        clear_expected();
        @(posedge clk); #1;
        reset_n = 1'b1;
        late = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rf_we === 1'b1 || in_ready === 1'b1) late++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (late != 0) begin n_fail++; $display("FAIL rst_load_abandon: got %0d active cycles expected 0", late); end
        fill_random_bytes();
        test_load(4'd9, 3, 1'b0);
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        out_ready = 1'b0;
        start_cmd(1'b1, 4'd0, 5'd8, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rst_dump_accept: cmd not accepted"); end
        for (int c = 0; c < 10; c++) begin
            if (out_valid === 1'b1) break;
            @(posedge clk); #1;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_dump_valid: got %b expected 1", out_valid); end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_dump_drop: got v=%b l=%b busy=%b expected 0 0 0", out_valid, out_last, busy);
        end
        clear_expected();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [3:0] base;
        int         len;
        for (int it = 0; it < 10; it++) begin
            base = 4'($urandom);
            len  = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 0) begin
                fill_random_bytes();
                test_load(base, len, 1'($urandom));
            end else begin
                test_dump(base, len, 2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();

        load_bytes = '{8'hA1, 8'hB2, 8'hC3};
        test_load(4'd2, 3, 1'b0);
        load_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        test_load(4'd14, 4, 1'b0);
        test_dump(4'd2, 3, 1);
        test_dump(4'd14, 4, 0);

        test_load(4'd7, 0, 1'b0);
        test_dump(4'd9, 0, 0);

        fill_random_bytes();
        test_load(4'd3, 20, 1'b0);
        test_dump(4'd3, 20, 2);
        test_dump(4'd0, 16, 0);

        test_reset_mid_load();
        test_reset_mid_dump();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
